latch_fifo: RTL and testbench
=============================

// Module: latch_fifo
// PURPOSE
//  Parametrised capture buffer for wide datapath words: queues up to DEPTH valid-tagged
//  words and presents the oldest one downstream with a ready/valid handshake.
//  Replaces single-entry capture latches between pipeline stages.
//  Provides an enable gate, a synchronous clear, a selectable overflow policy and a sticky
//  overflow flag.
// PARAMETERS
//  WIDTH      256  data width in bits (>=1)
//  DEPTH      4    number of entries (>=1; any integer, need not be a power of 2)
//  OVERWRITE  0    full policy: 0 = drop incoming word, 1 = overwrite oldest entry
// PORTS
//  clk         in   1                   clock, all state on rising edge
//  resetn      in   1                   asynchronous reset, active-low
//  enable_i    in   1                   capture enable; 0 = ignore valid_i
//  clear_i     in   1                   synchronous clear of all state
//  d_i         in   WIDTH               input word
//  valid_i     in   1                   input word valid
//  ready_o     out  1                   buffer accepts input this cycle
//  d_o         out  WIDTH               oldest stored word (head)
//  valid_o     out  1                   d_o holds a stored word
//  ready_i     in   1                   downstream consumes head when valid_o=1
//  count_o     out  $clog2(DEPTH+1)     occupied entries, 0..DEPTH
//  overflow_o  out  1                   sticky: a word was dropped or overwritten
// BEHAVIOUR
//  - Reset (resetn=0, asynchronous): storage, pointers and count are zeroed;
//    valid_o=0, d_o=0, count_o=0, overflow_o=0, ready_o=enable_i.
//  - clear_i=1 at a rising edge has the same effect as reset, synchronously.
//    clear_i has priority over a push or pop in the same cycle.
//  - Push: occurs when valid_i && enable_i at a rising edge. The word is written at the tail.
//  - Pop: occurs when valid_o && ready_i at a rising edge. The head advances.
//  - Latency: a word pushed at edge N appears on d_o/valid_o after edge N (1 cycle).
//    There is no combinational bypass from d_i to d_o.
//  - d_o is 0 whenever valid_o=0. Stale entries are never exposed.
//  - valid_o = (count_o != 0). count_o is updated registered with each push/pop.
//  - ready_o = enable_i && (count_o < DEPTH || OVERWRITE==1 || (valid_o && ready_i)).
//    ready_o is combinational from the inputs named.
//  - Pointers wrap from DEPTH-1 to 0. count never exceeds DEPTH or goes below 0.
//  - Simultaneous push+pop: the count is unchanged. This is legal when empty only if
//    count>0, so a push into an empty buffer with ready_i=1 performs the push only.
//  - Simultaneous push+pop when full: both are performed, no overflow, in either mode.
//  - Full, push, no pop, OVERWRITE=0: the word is dropped, state is unchanged, and
//    overflow_o is set.
//  - Full, push, no pop, OVERWRITE=1: the oldest entry is discarded (head advances),
//    the new word is written at the tail, count stays DEPTH, and overflow_o is set.
//  - overflow_o stays 1 until reset or clear_i.
//  - enable_i=0 blocks pushes only. Pops continue normally.
//  - DEPTH=1: a single register. Push+pop in the same cycle replaces the entry.
// TESTING
//  1. Reset: drive resetn=0 mid-stream with count=3 -> immediately valid_o=0, d_o=0,
//     count_o=0, overflow_o=0.
//  2. Order: DEPTH=4, push 0xA,0xB,0xC with ready_i=0, then ready_i=1 ->
//     d_o = A,B,C on consecutive cycles, then valid_o=0.
//  3. Drop: OVERWRITE=0, fill 1..4, push 5 with ready_i=0 -> count_o=4, overflow_o=1,
//     drain yields 1,2,3,4.
//  4. Overwrite: OVERWRITE=1, fill 1..4, push 5 -> count_o=4, overflow_o=1,
//     drain yields 2,3,4,5.
//  5. Full push+pop: count=4, valid_i=1, ready_i=1, d_i=9 -> count_o stays 4,
//     overflow_o=0, 9 is the last word drained.
//  6. Clear/enable: clear_i=1 together with push 7 -> count_o=0 next cycle;
//     enable_i=0 with valid_i=1 -> ready_o=0, no push.

Source files
------------

// File: rtl/latch_fifo.sv
// latch_fifo: capture buffer for wide datapath words.
//   Queues up to DEPTH words and presents the oldest one downstream with a
//   ready/valid handshake. Words pushed at a rising edge become visible on
//   d_o/valid_o after that edge; there is no path from d_i to d_o.
//
// Parameters
//   WIDTH     data width in bits
//   DEPTH     number of entries (any integer >= 1)
//   OVERWRITE full policy: 0 = drop incoming word, 1 = overwrite oldest entry
//
// Ports
//   clk        clock, rising edge
//   resetn     asynchronous reset, active-low
//   enable_i   capture enable (gates pushes only)
//   clear_i    synchronous clear of all state, wins over push/pop
//   d_i        input word
//   valid_i    input word valid
//   ready_o    buffer accepts input this cycle
//   d_o        head word, zero when valid_o=0
//   valid_o    head word present
//   ready_i    downstream consumes head when valid_o=1
//   count_o    occupied entries, 0..DEPTH
//   overflow_o sticky: a word was dropped or overwritten
module latch_fifo #(
  parameter int unsigned WIDTH     = 256,
  parameter int unsigned DEPTH     = 4,
  parameter bit          OVERWRITE = 1'b0
) (
  input  logic                         clk,
  input  logic                         resetn,
  input  logic                         enable_i,
  input  logic                         clear_i,
  input  logic [WIDTH-1:0]             d_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  output logic [WIDTH-1:0]             d_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         overflow_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    head_q, head_d;
  logic [PW-1:0]    tail_q, tail_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             mem_we_s;
  logic             valid_s;
  logic             push_req_s;
  logic             pop_s;
  logic             full_s;

  // Pointer increment that wraps at DEPTH-1, so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == LAST_PTR) begin
      return {PW{1'b0}};
    end else begin
      return p + PW'(1);
    end
  endfunction

  assign valid_s    = (count_q != {CW{1'b0}});
  assign push_req_s = valid_i && enable_i;
  assign pop_s      = valid_s && ready_i;
  assign full_s     = (count_q == FULL_CNT);

  // Next-state decode for pointers, occupancy and the sticky overflow flag.
  always_comb begin
    mem_we_s = 1'b0;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_req_s && (!full_s || pop_s)) begin
      // Normal push; a simultaneous pop keeps the count and also frees the head.
      mem_we_s = 1'b1;
      tail_d   = ptr_inc(tail_q);
      if (pop_s) begin
        head_d = ptr_inc(head_q);
      end else begin
        count_d = count_q + CW'(1);
      end
    end else if (push_req_s) begin
      // Full with no pop: the word is either dropped or replaces the oldest.
      ovf_d = 1'b1;
      if (OVERWRITE) begin
        mem_we_s = 1'b1;
        tail_d   = ptr_inc(tail_q);
        head_d   = ptr_inc(head_q);
      end else begin
        mem_we_s = 1'b0;
      end
    end else if (pop_s) begin
      head_d  = ptr_inc(head_q);
      count_d = count_q - CW'(1);
    end else begin
      count_d = count_q;
    end
  end

  // Control state register with async reset and synchronous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
    end else if (clear_i) begin
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array, zeroed on reset and clear so old data never lingers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (clear_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {WIDTH{1'b0}};
      end
    end else if (mem_we_s) begin
      mem_q[tail_q] <= d_i;
    end else begin
      mem_q[tail_q] <= mem_q[tail_q];
    end
  end

  // Output decode: head word is masked whenever the buffer is empty.
  always_comb begin
    valid_o    = valid_s;
    count_o    = count_q;
    overflow_o = ovf_q;
    ready_o    = enable_i && ((count_q < FULL_CNT) || OVERWRITE || pop_s);
    if (valid_s) begin
      d_o = mem_q[head_q];
    end else begin
      d_o = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_latch_fifo.sv
module tb_latch_fifo;

  localparam int W = 32;

  logic          clk;
  logic          resetn;
  logic          enable_i;
  logic          clear_i;
  logic [W-1:0]  d_i;
  logic          valid_i;
  logic          ready_i;

  logic          rdy_a, v_a, ovf_a;
  logic [W-1:0]  d_a;
  logic [2:0]    cnt_a;
  logic          rdy_b, v_b, ovf_b;
  logic [W-1:0]  d_b;
  logic [2:0]    cnt_b;
  logic          rdy_c, v_c, ovf_c;
  logic [W-1:0]  d_c;
  logic [0:0]    cnt_c;

  int n_vec = 0;
  int n_err = 0;

  // Instance A: drop policy, instance B: overwrite policy, instance C: single entry.
  latch_fifo #(.WIDTH(W), .DEPTH(4), .OVERWRITE(1'b0)) dut_a (
    .clk(clk), .resetn(resetn), .enable_i(enable_i), .clear_i(clear_i),
    .d_i(d_i), .valid_i(valid_i), .ready_o(rdy_a), .d_o(d_a), .valid_o(v_a),
    .ready_i(ready_i), .count_o(cnt_a), .overflow_o(ovf_a));

  latch_fifo #(.WIDTH(W), .DEPTH(4), .OVERWRITE(1'b1)) dut_b (
    .clk(clk), .resetn(resetn), .enable_i(enable_i), .clear_i(clear_i),
    .d_i(d_i), .valid_i(valid_i), .ready_o(rdy_b), .d_o(d_b), .valid_o(v_b),
    .ready_i(ready_i), .count_o(cnt_b), .overflow_o(ovf_b));

  latch_fifo #(.WIDTH(W), .DEPTH(1), .OVERWRITE(1'b0)) dut_c (
    .clk(clk), .resetn(resetn), .enable_i(enable_i), .clear_i(clear_i),
    .d_i(d_i), .valid_i(valid_i), .ready_o(rdy_c), .d_o(d_c), .valid_o(v_c),
    .ready_i(ready_i), .count_o(cnt_c), .overflow_o(ovf_c));

  // Per-instance views for the randomized scoreboard.
  logic          rdy_arr [3];
  logic          v_arr   [3];
  logic          ovf_arr [3];
  logic [W-1:0]  d_arr   [3];
  logic [2:0]    cnt_arr [3];
  assign rdy_arr[0] = rdy_a;  assign rdy_arr[1] = rdy_b;  assign rdy_arr[2] = rdy_c;
  assign v_arr[0]   = v_a;    assign v_arr[1]   = v_b;    assign v_arr[2]   = v_c;
  assign ovf_arr[0] = ovf_a;  assign ovf_arr[1] = ovf_b;  assign ovf_arr[2] = ovf_c;
  assign d_arr[0]   = d_a;    assign d_arr[1]   = d_b;    assign d_arr[2]   = d_c;
  assign cnt_arr[0] = cnt_a;  assign cnt_arr[1] = cnt_b;  assign cnt_arr[2] = {2'b00, cnt_c};

  // Reference model: one queue per instance plus a sticky overflow bit.
  localparam int DEP [3] = '{4, 4, 1};
  localparam bit OWA [3] = '{1'b0, 1'b1, 1'b0};
  logic [W-1:0] mq [3][$];
  bit           movf [3];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      mq[i].delete();
      movf[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 3; i++) begin
      bit push;
      bit pop;
      bit full;
      push = valid_i && enable_i;
      pop  = (mq[i].size() > 0) && ready_i;
      full = (mq[i].size() == DEP[i]);
      if (clear_i) begin
        mq[i].delete();
        movf[i] = 1'b0;
      end else begin
        if (pop) void'(mq[i].pop_front());
        if (push) begin
          if (!full || pop) begin
            mq[i].push_back(d_i);
          end else begin
            movf[i] = 1'b1;
            if (OWA[i]) begin
              void'(mq[i].pop_front());
              mq[i].push_back(d_i);
            end
          end
        end
      end
    end
  endtask

  // One clock: DUT and model both take the inputs set at the previous negedge.
  task automatic advance();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic push_word(input logic [W-1:0] w, input logic rdy);
    valid_i = 1'b1; d_i = w; ready_i = rdy;
    advance();
    valid_i = 1'b0; ready_i = 1'b0;
  endtask

  task automatic do_clear();
    clear_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
    advance();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({v_a, d_a, cnt_a, ovf_a, rdy_a} !== {1'b0, 32'h0, 3'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL reset_init: got %h expected %h", {v_a, d_a, cnt_a, ovf_a, rdy_a}, {1'b0, 32'h0, 3'd0, 1'b0, 1'b1});
    end
    push_word(32'h11, 1'b0);
    push_word(32'h22, 1'b0);
    push_word(32'h33, 1'b0);
    n_vec++;
    if (cnt_a !== 3'd3) begin n_err++; $display("FAIL reset_fill: got %0d expected 3", cnt_a); end
    #2 resetn = 1'b0;
    #1;
    n_vec++;
    if ({v_a, d_a, cnt_a, ovf_a, rdy_a} !== {1'b0, 32'h0, 3'd0, 1'b0, 1'b1}) begin
      n_err++; $display("FAIL reset_async: got %h expected %h", {v_a, d_a, cnt_a, ovf_a, rdy_a}, {1'b0, 32'h0, 3'd0, 1'b0, 1'b1});
    end
    enable_i = 1'b0;
    #1;
    n_vec++;
    if ({rdy_a, rdy_b} !== 2'b00) begin n_err++; $display("FAIL reset_ready_en0: got %b expected 00", {rdy_a, rdy_b}); end
    @(negedge clk);
    resetn = 1'b1; enable_i = 1'b1;
    model_clear();
  endtask

  task automatic test_order();
    do_clear();
    push_word(32'hA, 1'b0);
    push_word(32'hB, 1'b0);
    push_word(32'hC, 1'b0);
    ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      n_vec++;
      if ({v_a, d_a} !== {1'b1, 32'hA + k}) begin
        n_err++; $display("FAIL order_%0d: got %h expected %h", k, {v_a, d_a}, {1'b1, 32'hA + k});
      end
      advance();
    end
    n_vec++;
    if ({v_a, d_a} !== {1'b0, 32'h0}) begin n_err++; $display("FAIL order_empty: got %h expected 0", {v_a, d_a}); end
    ready_i = 1'b0;
  endtask

  task automatic test_drop_overwrite();
    do_clear();
    for (int k = 1; k <= 5; k++) push_word(32'(k), 1'b0);
    n_vec++;
    if ({cnt_a, ovf_a, cnt_b, ovf_b} !== {3'd4, 1'b1, 3'd4, 1'b1}) begin
      n_err++; $display("FAIL overflow_state: got %h expected %h", {cnt_a, ovf_a, cnt_b, ovf_b}, {3'd4, 1'b1, 3'd4, 1'b1});
    end
    ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_vec++;
      if ({d_a, d_b} !== {32'(k + 1), 32'(k + 2)}) begin
        n_err++; $display("FAIL drain_%0d: got %h expected %h", k, {d_a, d_b}, {32'(k + 1), 32'(k + 2)});
      end
      advance();
    end
    n_vec++;
    if ({v_a, v_b} !== 2'b00) begin n_err++; $display("FAIL drain_empty: got %b expected 00", {v_a, v_b}); end
    ready_i = 1'b0;
  endtask

  task automatic test_full_push_pop();
    do_clear();
    for (int k = 1; k <= 4; k++) push_word(32'(k), 1'b0);
    n_vec++;
    if ({rdy_a, rdy_b} !== 2'b01) begin n_err++; $display("FAIL full_ready: got %b expected 01", {rdy_a, rdy_b}); end
    valid_i = 1'b1; d_i = 32'h9; ready_i = 1'b1;
    #1;
    n_vec++;
    if ({rdy_a, rdy_b} !== 2'b11) begin n_err++; $display("FAIL full_ready_pop: got %b expected 11", {rdy_a, rdy_b}); end
    advance();
    valid_i = 1'b0;
    n_vec++;
    if ({cnt_a, ovf_a, cnt_b, ovf_b} !== {3'd4, 1'b0, 3'd4, 1'b0}) begin
      n_err++; $display("FAIL full_pp_state: got %h expected %h", {cnt_a, ovf_a, cnt_b, ovf_b}, {3'd4, 1'b0, 3'd4, 1'b0});
    end
    for (int k = 0; k < 4; k++) begin
      logic [W-1:0] e;
      e = (k == 3) ? 32'h9 : 32'(k + 2);
      n_vec++;
      if ({d_a, d_b} !== {e, e}) begin
        n_err++; $display("FAIL full_pp_drain_%0d: got %h expected %h", k, {d_a, d_b}, {e, e});
      end
      advance();
    end
    ready_i = 1'b0;
  endtask

  task automatic test_clear_enable();
    push_word(32'h5, 1'b0);
    push_word(32'h6, 1'b0);
    clear_i = 1'b1; valid_i = 1'b1; d_i = 32'h7;
    advance();
    clear_i = 1'b0; valid_i = 1'b0;
    n_vec++;
    if ({v_a, cnt_a, ovf_a, v_b, cnt_b} !== 9'b0) begin
      n_err++; $display("FAIL clear: got %h expected 0", {v_a, cnt_a, ovf_a, v_b, cnt_b});
    end
    enable_i = 1'b0; valid_i = 1'b1; d_i = 32'h8;
    #1;
    n_vec++;
    if ({rdy_a, rdy_b, rdy_c} !== 3'b000) begin n_err++; $display("FAIL en0_ready: got %b expected 000", {rdy_a, rdy_b, rdy_c}); end
    advance();
    n_vec++;
    if ({cnt_a, cnt_b} !== 6'd0) begin n_err++; $display("FAIL en0_nopush: got %h expected 0", {cnt_a, cnt_b}); end
    enable_i = 1'b1;
    push_word(32'h3, 1'b0);
    enable_i = 1'b0; valid_i = 1'b1; ready_i = 1'b1;
    advance();
    n_vec++;
    if ({v_a, cnt_a} !== 4'd0) begin n_err++; $display("FAIL en0_pop: got %h expected 0", {v_a, cnt_a}); end
    enable_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0;
  endtask

  task automatic test_depth1();
    do_clear();
    push_word(32'h100, 1'b0);
    n_vec++;
    if ({v_c, d_c, cnt_c} !== {1'b1, 32'h100, 1'b1}) begin n_err++; $display("FAIL d1_push: got %h expected %h", {v_c, d_c, cnt_c}, {1'b1, 32'h100, 1'b1}); end
    push_word(32'h200, 1'b1);
    n_vec++;
    if ({v_c, d_c, cnt_c, ovf_c} !== {1'b1, 32'h200, 1'b1, 1'b0}) begin n_err++; $display("FAIL d1_replace: got %h expected %h", {v_c, d_c, cnt_c, ovf_c}, {1'b1, 32'h200, 1'b1, 1'b0}); end
    push_word(32'h300, 1'b0);
    n_vec++;
    if ({v_c, d_c, cnt_c, ovf_c} !== {1'b1, 32'h200, 1'b1, 1'b1}) begin n_err++; $display("FAIL d1_drop: got %h expected %h", {v_c, d_c, cnt_c, ovf_c}, {1'b1, 32'h200, 1'b1, 1'b1}); end
  endtask

  task automatic test_random();
    do_clear();
    for (int n = 0; n < 500; n++) begin
      clear_i  = ($urandom_range(0, 39) == 0);
      enable_i = ($urandom_range(0, 7) != 0);
      valid_i  = ($urandom_range(0, 2) != 0);
      ready_i  = $urandom_range(0, 1) == 1;
      d_i      = $urandom;
      #1;
      for (int i = 0; i < 3; i++) begin
        logic         ev;
        logic [W-1:0] ed;
        logic         er;
        ev = (mq[i].size() > 0);
        ed = ev ? mq[i][0] : 32'h0;
        er = enable_i && ((mq[i].size() < DEP[i]) || OWA[i] || (ev && ready_i));
        n_vec++;
        if ({v_arr[i], d_arr[i], cnt_arr[i], ovf_arr[i]} !== {ev, ed, 3'(mq[i].size()), movf[i]}) begin
          n_err++; $display("FAIL rand_state[%0d] cyc %0d: got %h expected %h", i, n,
                            {v_arr[i], d_arr[i], cnt_arr[i], ovf_arr[i]}, {ev, ed, 3'(mq[i].size()), movf[i]});
        end
        n_vec++;
        if (rdy_arr[i] !== er) begin
          n_err++; $display("FAIL rand_ready[%0d] cyc %0d: got %b expected %b", i, n, rdy_arr[i], er);
        end
      end
      advance();
    end
    clear_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; enable_i = 1'b1;
  endtask

  initial begin
    resetn = 1'b0; enable_i = 1'b1; clear_i = 1'b0;
    d_i = 32'h0; valid_i = 1'b0; ready_i = 1'b0;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    test_reset();
    test_order();
    test_drop_overwrite();
    test_full_push_pop();
    test_clear_enable();
    test_depth1();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
